tlu_emulator: RTL and testbench



---
 rtl/tlu_emulator.sv | 233 +++++++++++++++++++++++
 tb/tb_tlu_emulator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlu_emulator.sv
// TLU-side emulator for EUDET TLU handshakes: periodic/soft triggers, busy veto, serial trigger-number shift-out.
// Request to TLU_TRIGGER in 1 cycle, busy/clock reactions after 3; requests arriving while not IDLE are dropped and counted.
`timescale 1ns/1ps
module tlu_emulator #(
    parameter int DATA_BITS    = 15,
    parameter int PULSE_LEN    = 4,
    parameter int RESET_LEN    = 4,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic [1:0]           MODE,
    input  logic [15:0]          TRIGGER_PERIOD,
    input  logic                 SOFT_TRIGGER,
    input  logic                 SOFT_TLU_RESET,
    input  logic                 TLU_BUSY,
    input  logic                 TLU_CLOCK,
    output logic                 TLU_TRIGGER,
    output logic                 TLU_RESET,
    output logic [DATA_BITS-1:0] TRIGGER_NUMBER,
    output logic [15:0]          MISSED_COUNT,
    output logic                 TIMEOUT_FLAG,
    output logic                 EMU_BUSY
);

    localparam int CNT_MAX_A = (PULSE_LEN > RESET_LEN) ? PULSE_LEN : RESET_LEN;
    localparam int CNT_MAX   = (CNT_MAX_A > BUSY_TIMEOUT) ? CNT_MAX_A : BUSY_TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_LEN - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_DATA   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT_BUSY,
        S_SHIFT,
        S_WAIT_RELEASE,
        S_DONE,
        S_RESET_OUT
    } state_t;

    state_t                 state, state_nxt;

    logic                   busy_meta, busy_sync;
    logic                   tclk_meta, tclk_sync, tclk_prev;
    logic                   tclk_edge;

    logic [15:0]            per_cnt, per_cnt_nxt;
    logic                   per_run, per_req;
    logic                   req, pend_eff, accept;

    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0]       bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0]   num_lat, num_lat_nxt;
    logic [1:0]             mode_lat, mode_lat_nxt;

    logic                   trig_q, trig_nxt;
    logic                   rst_q, rst_nxt;
    logic [DATA_BITS-1:0]   num_q, num_nxt;
    logic [15:0]            missed_q, missed_nxt;
    logic                   timeout_q, timeout_nxt;
    logic                   pend_q, pend_nxt;

    assign tclk_edge = tclk_sync & ~tclk_prev;

    // Period generator and request arbitration
    always_comb begin
        per_run     = ENABLE && (MODE != MODE_OFF) && (TRIGGER_PERIOD != 16'd0);
        per_req     = per_run && (per_cnt >= (TRIGGER_PERIOD - 16'd1));
        per_cnt_nxt = (!per_run || per_req) ? 16'd0 : per_cnt + 16'd1;

        req      = per_req | SOFT_TRIGGER;
        pend_eff = pend_q | SOFT_TLU_RESET;
        accept   = req && (state == S_IDLE) && (MODE != MODE_OFF) && !pend_eff &&
                   ((MODE == MODE_PULSE) || !busy_sync);

        missed_nxt = missed_q;
        if (req && (MODE != MODE_OFF) && !accept && (missed_q != 16'hFFFF))
            missed_nxt = missed_q + 16'd1;
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        num_lat_nxt  = num_lat;
        mode_lat_nxt = mode_lat;
        trig_nxt     = trig_q;
        rst_nxt      = rst_q;
        num_nxt      = num_q;
        timeout_nxt  = 1'b0;
        pend_nxt     = pend_eff;

        case (state)
            S_IDLE: begin
                trig_nxt = 1'b0;
                if (pend_eff) begin
                    state_nxt = S_RESET_OUT;
                    rst_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    num_nxt   = '0;
                end else if (accept) begin
                    mode_lat_nxt = MODE;
                    num_lat_nxt  = num_q;
                    trig_nxt     = 1'b1;
                    cnt_nxt      = '0;
                    bit_idx_nxt  = '0;
                    state_nxt    = (MODE == MODE_PULSE) ? S_PULSE : S_WAIT_BUSY;
                end
            end

            S_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    trig_nxt  = 1'b0;
                    num_nxt   = num_q + DATA_BITS'(1);
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_WAIT_BUSY: begin
                if (busy_sync) begin
                    trig_nxt  = 1'b0;
                    state_nxt = (mode_lat == MODE_DATA) ? S_SHIFT : S_WAIT_RELEASE;
                end else if (cnt == TIMEOUT_LAST) begin
                    trig_nxt    = 1'b0;
                    timeout_nxt = 1'b1;
                    num_nxt     = num_q + DATA_BITS'(1);
                    state_nxt   = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            // No timeout here: a stalled DUT clock parks the emulator until reset.
            S_SHIFT: begin
                if (tclk_edge) begin
                    trig_nxt = num_lat[bit_idx];
                    if (bit_idx == IDX_LAST)
                        state_nxt = S_WAIT_RELEASE;
                    else
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                end
            end

            S_WAIT_RELEASE: begin
                if (!busy_sync) begin
                    trig_nxt  = 1'b0;
                    num_nxt   = num_q + DATA_BITS'(1);
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            S_RESET_OUT: begin
                if (cnt == RESET_LAST) begin
                    rst_nxt   = 1'b0;
                    pend_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                trig_nxt  = 1'b0;
                rst_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
            tclk_meta <= 1'b0;
            tclk_sync <= 1'b0;
            tclk_prev <= 1'b0;
            per_cnt   <= 16'd0;
            cnt       <= '0;
            bit_idx   <= '0;
            num_lat   <= '0;
            mode_lat  <= MODE_OFF;
            trig_q    <= 1'b0;
            rst_q     <= 1'b0;
            num_q     <= '0;
            missed_q  <= 16'd0;
            timeout_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy_meta <= TLU_BUSY;
            busy_sync <= busy_meta;
            tclk_meta <= TLU_CLOCK;
            tclk_sync <= tclk_meta;
            tclk_prev <= tclk_sync;
            per_cnt   <= per_cnt_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            num_lat   <= num_lat_nxt;
            mode_lat  <= mode_lat_nxt;
            trig_q    <= trig_nxt;
            rst_q     <= rst_nxt;
            num_q     <= num_nxt;
            missed_q  <= missed_nxt;
            timeout_q <= timeout_nxt;
            pend_q    <= pend_nxt;
        end
    end

    assign TLU_TRIGGER    = trig_q;
    assign TLU_RESET      = rst_q;
    assign TRIGGER_NUMBER = num_q;
    assign MISSED_COUNT   = missed_q;
    assign TIMEOUT_FLAG   = timeout_q;
    assign EMU_BUSY       = (state != S_IDLE);

endmodule

// File: tb/tb_tlu_emulator.sv
// Directed bench for tlu_emulator with hand-computed expectations for each handshake mode.
`timescale 1ns/1ps
module tb_tlu_emulator;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        ENABLE;
    logic [1:0]  MODE;
    logic [15:0] TRIGGER_PERIOD;
    logic        SOFT_TRIGGER;
    logic        SOFT_TLU_RESET;
    logic        TLU_BUSY;
    logic        TLU_CLOCK;
    logic        TLU_TRIGGER;
    logic        TLU_RESET;
    logic [14:0] TRIGGER_NUMBER;
    logic [15:0] MISSED_COUNT;
    logic        TIMEOUT_FLAG;
    logic        EMU_BUSY;

    int errors = 0;
    int checks = 0;

    tlu_emulator #(
        .DATA_BITS(15), .PULSE_LEN(4), .RESET_LEN(4), .BUSY_TIMEOUT(1024)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .MODE(MODE),
        .TRIGGER_PERIOD(TRIGGER_PERIOD), .SOFT_TRIGGER(SOFT_TRIGGER),
        .SOFT_TLU_RESET(SOFT_TLU_RESET), .TLU_BUSY(TLU_BUSY), .TLU_CLOCK(TLU_CLOCK),
        .TLU_TRIGGER(TLU_TRIGGER), .TLU_RESET(TLU_RESET), .TRIGGER_NUMBER(TRIGGER_NUMBER),
        .MISSED_COUNT(MISSED_COUNT), .TIMEOUT_FLAG(TIMEOUT_FLAG), .EMU_BUSY(EMU_BUSY)
    );

    always #12.5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0; ENABLE = 1'b0; MODE = 2'b00; TRIGGER_PERIOD = 16'd0;
        SOFT_TRIGGER = 1'b0; SOFT_TLU_RESET = 1'b0; TLU_BUSY = 1'b0; TLU_CLOCK = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic soft_trig();
        SOFT_TRIGGER = 1'b1;
        @(negedge CLK);
        SOFT_TRIGGER = 1'b0;
    endtask

    task automatic wait_trig(input logic v, input int bound, output int n);
        n = 0;
        while (TLU_TRIGGER !== v && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (TLU_TRIGGER !== v) n = -1;
    endtask

    task automatic wait_num(input logic [14:0] v, input int bound, output int n);
        n = 0;
        while (TRIGGER_NUMBER !== v && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (TRIGGER_NUMBER !== v) n = -1;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (EMU_BUSY !== 1'b0 && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (EMU_BUSY !== 1'b0) n = -1;
    endtask

    task automatic tlu_clock_edges(input int count, output logic [14:0] bits);
        bits = '0;
        for (int i = 0; i < count; i++) begin
            TLU_CLOCK = 1'b1;
            repeat (4) @(negedge CLK);
            if (i < 15) bits[i] = TLU_TRIGGER;
            TLU_CLOCK = 1'b0;
            repeat (4) @(negedge CLK);
        end
    endtask

    initial begin
        int n;
        int pulses;
        int good_width;
        int width;
        logic prev;
        logic [14:0] bits;

        do_reset();
        check_val("rst_trigger", {31'd0, TLU_TRIGGER}, 32'd0);
        check_val("rst_tlu_reset", {31'd0, TLU_RESET}, 32'd0);
        check_val("rst_number", {17'd0, TRIGGER_NUMBER}, 32'd0);
        check_val("rst_missed", {16'd0, MISSED_COUNT}, 32'd0);
        check_val("rst_timeout", {31'd0, TIMEOUT_FLAG}, 32'd0);
        check_val("rst_busy", {31'd0, EMU_BUSY}, 32'd0);

        // Periodic no-handshake pulses: 100 enabled cycles at period 10.
        MODE = 2'b01; TRIGGER_PERIOD = 16'd10; ENABLE = 1'b1;
        pulses = 0; good_width = 0; width = 0; prev = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            if (i == 99) ENABLE = 1'b0;
            if (TLU_TRIGGER && !prev) pulses++;
            if (TLU_TRIGGER) width++;
            if (!TLU_TRIGGER && prev) begin
                if (width == 4) good_width++;
                width = 0;
            end
            prev = TLU_TRIGGER;
        end
        check_val("per_pulses", pulses, 10);
        check_val("per_width4", good_width, 10);
        check_val("per_number", {17'd0, TRIGGER_NUMBER}, 32'd10);
        check_val("per_missed", {16'd0, MISSED_COUNT}, 32'd0);

        // Simple handshake.
        do_reset();
        MODE = 2'b10;
        soft_trig();
        check_val("hs_trig_on", {31'd0, TLU_TRIGGER}, 32'd1);
        repeat (5) @(negedge CLK);
        TLU_BUSY = 1'b1;
        wait_trig(1'b0, 20, n);
        check_val("hs_busy_to_fall", n, 3);
        repeat (17) @(negedge CLK);
        check_val("hs_release_trig", {31'd0, TLU_TRIGGER}, 32'd0);
        check_val("hs_release_num", {17'd0, TRIGGER_NUMBER}, 32'd0);
        TLU_BUSY = 1'b0;
        wait_num(15'd1, 20, n);
        check_val("hs_num_latency", n, 3);
        check_val("hs_done_busy", {31'd0, EMU_BUSY}, 32'd1);
        @(negedge CLK);
        check_val("hs_idle_busy", {31'd0, EMU_BUSY}, 32'd0);

        // Busy timeout.
        do_reset();
        MODE = 2'b10;
        soft_trig();
        n = 0;
        while (TIMEOUT_FLAG !== 1'b1 && n < 1100) begin
            @(negedge CLK);
            n++;
        end
        check_val("to_cycles", n, 1024);
        check_val("to_trig_low", {31'd0, TLU_TRIGGER}, 32'd0);
        check_val("to_number", {17'd0, TRIGGER_NUMBER}, 32'd1);
        @(negedge CLK);
        check_val("to_flag_pulse", {31'd0, TIMEOUT_FLAG}, 32'd0);
        check_val("to_idle", {31'd0, EMU_BUSY}, 32'd0);
        soft_trig();
        check_val("to_next_accept", {31'd0, TLU_TRIGGER}, 32'd1);

        // Missed requests and TLU reset.
        do_reset();
        MODE = 2'b10;
        soft_trig();
        repeat (5) @(negedge CLK);
        TLU_BUSY = 1'b1;
        wait_trig(1'b0, 20, n);
        soft_trig();
        check_val("miss_in_release", {16'd0, MISSED_COUNT}, 32'd1);
        TLU_BUSY = 1'b0;
        wait_idle(20, n);
        check_val("miss_num_before", {17'd0, TRIGGER_NUMBER}, 32'd1);
        SOFT_TRIGGER = 1'b1; SOFT_TLU_RESET = 1'b1;
        @(negedge CLK);
        SOFT_TRIGGER = 1'b0; SOFT_TLU_RESET = 1'b0;
        check_val("miss_with_reset", {16'd0, MISSED_COUNT}, 32'd2);
        check_val("tlurst_number", {17'd0, TRIGGER_NUMBER}, 32'd0);
        check_val("tlurst_trig", {31'd0, TLU_TRIGGER}, 32'd0);
        width = 0;
        for (int i = 0; i < 12; i++) begin
            if (TLU_RESET) width++;
            @(negedge CLK);
        end
        check_val("tlurst_width", width, 4);
        check_val("tlurst_idle", {31'd0, EMU_BUSY}, 32'd0);

        // Trigger-data handshake with preloaded number 0x2A5B.
        do_reset();
        MODE = 2'b01; TRIGGER_PERIOD = 16'd6; ENABLE = 1'b1;
        wait_num(15'h2A5B, 70000, n);
        ENABLE = 1'b0;
        check_val("pre_number", {17'd0, TRIGGER_NUMBER}, 32'h2A5B);
        wait_idle(20, n);
        check_val("pre_missed", {16'd0, MISSED_COUNT}, 32'd0);
        MODE = 2'b11;
        soft_trig();
        check_val("td_trig_on", {31'd0, TLU_TRIGGER}, 32'd1);
        repeat (5) @(negedge CLK);
        TLU_BUSY = 1'b1;
        wait_trig(1'b0, 20, n);
        check_val("td_busy_to_fall", n, 3);
        tlu_clock_edges(15, bits);
        check_val("td_bits", {17'd0, bits}, 32'h2A5B);
        tlu_clock_edges(1, bits);
        check_val("td_extra_edge", {31'd0, TLU_TRIGGER}, 32'd0);
        check_val("td_busy_hold", {31'd0, EMU_BUSY}, 32'd1);
        TLU_BUSY = 1'b0;
        wait_num(15'h2A5C, 20, n);
        check_val("td_num_latency", n, 3);
        check_val("td_trig_low", {31'd0, TLU_TRIGGER}, 32'd0);

        // Reset during shift after bit 7 of 0x2A80.
        wait_idle(20, n);
        MODE = 2'b01; ENABLE = 1'b1;
        wait_num(15'h2A80, 1000, n);
        ENABLE = 1'b0;
        wait_idle(20, n);
        MODE = 2'b11;
        soft_trig();
        repeat (5) @(negedge CLK);
        TLU_BUSY = 1'b1;
        wait_trig(1'b0, 20, n);
        tlu_clock_edges(8, bits);
        check_val("sr_bit7", {31'd0, TLU_TRIGGER}, 32'd1);
        check_val("sr_bits_low", {24'd0, bits[7:0]}, 32'h80);
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        check_val("sr_trig", {31'd0, TLU_TRIGGER}, 32'd0);
        check_val("sr_state_idle", {31'd0, EMU_BUSY}, 32'd0);
        check_val("sr_number", {17'd0, TRIGGER_NUMBER}, 32'd0);
        check_val("sr_missed", {16'd0, MISSED_COUNT}, 32'd0);
        check_val("sr_tlu_reset", {31'd0, TLU_RESET}, 32'd0);
        check_val("sr_timeout", {31'd0, TIMEOUT_FLAG}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        TLU_BUSY = 1'b0;
        repeat (5) @(negedge CLK);
        check_val("sr_stays_idle", {31'd0, EMU_BUSY}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
